// File: rtl/vco_compare_sched.sv
// vco_compare_sched: settles, counts VCO1/VCO2 ticks over a fixed window, then reports which is faster
//   i_clk        system clock, rising edge
//   i_resetAll   asynchronous active-high reset
//   i_start      measurement request, honoured only in IDLE
//   i_cont       continuous mode, sampled in DONE to start a new round
//   i_vco1_tick  one-cycle VCO1 tick pulse, synchronous to i_clk
//   i_vco2_tick  one-cycle VCO2 tick pulse, synchronous to i_clk
//   o_busy       high in SETTLE, MEASURE and COMPARE
//   o_done       one-cycle pulse while results are fresh
//   o_vco1_fast  count1 > count2 for the last completed window
//   o_count1     VCO1 ticks of the last window (saturated)
//   o_count2     VCO2 ticks of the last window (saturated)
//   o_sat        a tick counter saturated in the last window
module vco_compare_sched #(
    parameter int SETTLE_CYCLES = 4,
    parameter int WIN_CYCLES    = 16,
    parameter int CNT_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_resetAll,
    input  logic             i_start,
    input  logic             i_cont,
    input  logic             i_vco1_tick,
    input  logic             i_vco2_tick,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_vco1_fast,
    output logic [CNT_W-1:0] o_count1,
    output logic [CNT_W-1:0] o_count2,
    output logic             o_sat
);
    localparam int MAXC = (SETTLE_CYCLES > WIN_CYCLES) ? SETTLE_CYCLES : WIN_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0]    S_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]    W_LAST = CW'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMAX   = '1;

    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, COMPARE, DONE} state_t;

    state_t           state, next_state;
    logic [CW-1:0]    cyc;
    logic [CNT_W-1:0] cnt1, cnt2;
    logic             sat;
    logic             clear;

    // a new round begins from IDLE on start, or straight from DONE in continuous mode
    assign clear = (state == IDLE && i_start) || (state == DONE && i_cont);

    always_ff @(posedge i_clk or posedge i_resetAll) begin
        if (i_resetAll) state <= IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = i_start ? SETTLE : IDLE;
            SETTLE:  next_state = (cyc == S_LAST) ? MEASURE : SETTLE;
            MEASURE: next_state = (cyc == W_LAST) ? COMPARE : MEASURE;
            COMPARE: next_state = DONE;
            DONE:    next_state = i_cont ? SETTLE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state == SETTLE) || (state == MEASURE) || (state == COMPARE);
        o_done = (state == DONE);
    end

    always_ff @(posedge i_clk or posedge i_resetAll) begin
        if (i_resetAll)
            cyc <= '0;
        else if (clear || (state == SETTLE && cyc == S_LAST))
            cyc <= '0;
        else if (state == SETTLE || state == MEASURE)
            cyc <= cyc + 1'b1;
    end

    // a tick arriving while its counter is already full is dropped and flagged
    always_ff @(posedge i_clk or posedge i_resetAll) begin
        if (i_resetAll) begin
            cnt1 <= '0;
            cnt2 <= '0;
            sat  <= 1'b0;
        end else if (clear) begin
            cnt1 <= '0;
            cnt2 <= '0;
            sat  <= 1'b0;
        end else if (state == MEASURE) begin
            cnt1 <= cnt1 + CNT_W'(i_vco1_tick && cnt1 != CMAX);
            cnt2 <= cnt2 + CNT_W'(i_vco2_tick && cnt2 != CMAX);
            sat  <= sat | (i_vco1_tick && cnt1 == CMAX) | (i_vco2_tick && cnt2 == CMAX);
        end
    end

    always_ff @(posedge i_clk or posedge i_resetAll) begin
        if (i_resetAll) begin
            o_count1    <= '0;
            o_count2    <= '0;
            o_vco1_fast <= 1'b0;
            o_sat       <= 1'b0;
        end else if (state == COMPARE) begin
            o_count1    <= cnt1;
            o_count2    <= cnt2;
            o_vco1_fast <= cnt1 > cnt2;
            o_sat       <= sat;
        end
    end
endmodule
